// File: rtl/adc_config_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_config_sequencer_if
// Bundles the host-side table/command signals and the ADC-control outputs of
// the ADC configuration sequencer. Clock and reset stay outside the interface.
//   master : host side (drives the i* signals, observes the o* signals)
//   slave  : sequencer side (observes the i* signals, drives the o* signals)
// Signals:
//   iCmdWrEn/iCmdWrAddr/iCmdWrData : table write port, entry = {addr, data}
//   iCmdCount/iSkipReset/iDoSync   : sequence options, sampled on iStart
//   iStart/iAbort                  : sequence control
//   oAdcControlComm/oAdcSerialCmd  : command byte and serial word to the ADC
//   oCmdIndex/oBusy/oDone/oError   : progress and status
// ---------------------------------------------------------------------------
interface adc_config_sequencer_if;
  logic        iCmdWrEn;
  logic [3:0]  iCmdWrAddr;
  logic [23:0] iCmdWrData;
  logic [4:0]  iCmdCount;
  logic        iSkipReset;
  logic        iDoSync;
  logic        iStart;
  logic        iAbort;
  logic [7:0]  oAdcControlComm;
  logic [23:0] oAdcSerialCmd;
  logic [3:0]  oCmdIndex;
  logic        oBusy;
  logic        oDone;
  logic        oError;

  modport master (
    output iCmdWrEn, iCmdWrAddr, iCmdWrData, iCmdCount, iSkipReset, iDoSync,
           iStart, iAbort,
    input  oAdcControlComm, oAdcSerialCmd, oCmdIndex, oBusy, oDone, oError
  );

  modport slave (
    input  iCmdWrEn, iCmdWrAddr, iCmdWrData, iCmdCount, iSkipReset, iDoSync,
           iStart, iAbort,
    output oAdcControlComm, oAdcSerialCmd, oCmdIndex, oBusy, oDone, oError
  );
endinterface

// File: rtl/adc_config_sequencer.sv
// ---------------------------------------------------------------------------
// adc_config_sequencer
// Plays back a host-loaded table of up to 16 serial register writes to the
// ADC control logic as a timed command sequence:
//   hardware reset (0xFF) -> 0x00 -> per entry {0x01 buffer, 0x02 issue,
//   0x00 gap} -> optional {0x04 sync, 0x00} -> idle.
// The downstream logic reacts only to a change of command byte, hence the
// 0x00 gap after every command.
// Ports:
//   sys_clk : system clock, all timing counted in these cycles
//   iReset  : asynchronous reset, active-high
//   bus     : adc_config_sequencer_if.slave (table write, start/abort,
//             command byte, serial word, index, busy/done/error)
// ---------------------------------------------------------------------------
module adc_config_sequencer #(
  parameter int RESET_CYCLES = 500,
  parameter int HOLD_CYCLES  = 100,
  parameter int ISSUE_CYCLES = 1000,
  parameter int SYNC_CYCLES  = 200
) (
  input  logic                        sys_clk,
  input  logic                        iReset,
  adc_config_sequencer_if.slave       bus
);

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_BUF   = 8'h01;
  localparam logic [7:0] CMD_ISSUE = 8'h02;
  localparam logic [7:0] CMD_SYNC  = 8'h04;

  // Counter reload values: a phase of N cycles loads N-1 and leaves at 0.
  localparam logic [15:0] RESET_LD = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] ISSUE_LD = 16'(ISSUE_CYCLES - 1);
  localparam logic [15:0] SYNC_LD  = 16'(SYNC_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HWRST    = 4'd1,
    S_POSTRST  = 4'd2,
    S_BUF      = 4'd3,
    S_ISSUE    = 4'd4,
    S_GAP      = 4'd5,
    S_SYNC     = 4'd6,
    S_POSTSYNC = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [4:0]  r_count;
  logic        r_sync;
  logic [3:0]  r_idx;
  logic [7:0]  r_comm;
  logic [23:0] r_serial;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [23:0] r_table [16];

  logic        w_cnt_zero;
  logic [4:0]  w_idx_next;
  logic        w_more;

  assign w_cnt_zero = (r_cnt == 16'd0);
  assign w_idx_next = {1'b0, r_idx} + 5'd1;
  assign w_more     = (w_idx_next < r_count);

  // Command table: writable only while no sequence is running, so playback
  // sees a frozen table. Contents are deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (bus.iCmdWrEn && !r_busy) begin
      r_table[bus.iCmdWrAddr] <= bus.iCmdWrData;
    end
  end

  // Sequencer FSM with registered command/status outputs.
  always_ff @(posedge sys_clk or posedge iReset) begin
    if (iReset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_count  <= 5'd0;
      r_sync   <= 1'b0;
      r_idx    <= 4'd0;
      r_comm   <= CMD_IDLE;
      r_serial <= 24'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      // Abort wins over any counter expiry in the same cycle.
      if (r_busy && bus.iAbort) begin
        r_state <= S_IDLE;
        r_comm  <= CMD_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 16'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.iStart) begin
              if (bus.iCmdCount > 5'd16) begin
                r_error <= 1'b1;
              end else begin
                r_count <= bus.iCmdCount;
                r_sync  <= bus.iDoSync;
                r_idx   <= 4'd0;
                r_busy  <= 1'b1;
                if (bus.iSkipReset) begin
                  r_state <= S_POSTRST;
                  r_comm  <= CMD_IDLE;
                  r_cnt   <= HOLD_LD;
                end else begin
                  r_state <= S_HWRST;
                  r_comm  <= CMD_RESET;
                  r_cnt   <= RESET_LD;
                end
              end
            end
          end
          S_HWRST: begin
            if (w_cnt_zero) begin
              r_state <= S_POSTRST;
              r_comm  <= CMD_IDLE;
              r_cnt   <= HOLD_LD;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_POSTRST: begin
            if (w_cnt_zero) begin
              if (r_count != 5'd0) begin
                r_state  <= S_BUF;
                r_comm   <= CMD_BUF;
                r_serial <= r_table[r_idx];
                r_cnt    <= HOLD_LD;
              end else if (r_sync) begin
                r_state <= S_SYNC;
                r_comm  <= CMD_SYNC;
                r_cnt   <= SYNC_LD;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_BUF: begin
            if (w_cnt_zero) begin
              r_state <= S_ISSUE;
              r_comm  <= CMD_ISSUE;
              r_cnt   <= ISSUE_LD;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_ISSUE: begin
            if (w_cnt_zero) begin
              r_state <= S_GAP;
              r_comm  <= CMD_IDLE;
              r_cnt   <= HOLD_LD;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_GAP: begin
            if (w_cnt_zero) begin
              if (w_more) begin
                r_state  <= S_BUF;
                r_comm   <= CMD_BUF;
                r_idx    <= w_idx_next[3:0];
                r_serial <= r_table[w_idx_next[3:0]];
                r_cnt    <= HOLD_LD;
              end else if (r_sync) begin
                r_state <= S_SYNC;
                r_comm  <= CMD_SYNC;
                r_cnt   <= SYNC_LD;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_SYNC: begin
            if (w_cnt_zero) begin
              r_state <= S_POSTSYNC;
              r_comm  <= CMD_IDLE;
              r_cnt   <= HOLD_LD;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_POSTSYNC: begin
            if (w_cnt_zero) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_comm  <= CMD_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_comm  <= CMD_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 16'd0;
          end
        endcase
      end
    end
  end

  assign bus.oAdcControlComm = r_comm;
  assign bus.oAdcSerialCmd   = r_serial;
  assign bus.oCmdIndex       = r_idx;
  assign bus.oBusy           = r_busy;
  assign bus.oDone           = r_done;
  assign bus.oError          = r_error;

endmodule

// File: tb/tb_adc_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_config_sequencer
// Directed bench for adc_config_sequencer with short phase lengths
// (RESET=6 HOLD=4 ISSUE=8 SYNC=5). Expected per-cycle output records
// {comm, serial, index, busy, done, error} are queued when a stimulus step is
// driven and popped/compared each cycle on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adc_config_sequencer;

  localparam int RST_N   = 6;
  localparam int HOLD_N  = 4;
  localparam int ISSUE_N = 8;
  localparam int SYNC_N  = 5;

  typedef struct packed {
    logic [7:0]  comm;
    logic [23:0] serial;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic        error;
  } rec_t;

  logic sys_clk;
  logic iReset;

  adc_config_sequencer_if bus ();

  adc_config_sequencer #(
    .RESET_CYCLES (RST_N),
    .HOLD_CYCLES  (HOLD_N),
    .ISSUE_CYCLES (ISSUE_N),
    .SYNC_CYCLES  (SYNC_N)
  ) dut (
    .sys_clk (sys_clk),
    .iReset  (iReset),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  rec_t        sb_q[$];
  logic [23:0] tbl [16];
  logic [23:0] e_serial;
  logic [3:0]  e_idx;

  function automatic rec_t observe();
    rec_t r;
    r.comm   = bus.oAdcControlComm;
    r.serial = bus.oAdcSerialCmd;
    r.idx    = bus.oCmdIndex;
    r.busy   = bus.oBusy;
    r.done   = bus.oDone;
    r.error  = bus.oError;
    return r;
  endfunction

  task automatic check(input string tag, input rec_t obs, input rec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed comm=%h ser=%h idx=%0d busy=%b done=%b err=%b expected comm=%h ser=%h idx=%0d busy=%b done=%b err=%b",
             tag, obs.comm, obs.serial, obs.idx, obs.busy, obs.done, obs.error,
             exp.comm, exp.serial, exp.idx, exp.busy, exp.done, exp.error);
    end
  endtask

  task automatic push_rec(input logic [7:0] c, input logic b, input logic d, input logic e);
    rec_t r;
    r.comm = c; r.serial = e_serial; r.idx = e_idx;
    r.busy = b; r.done = d; r.error = e;
    sb_q.push_back(r);
  endtask

  task automatic push_phase(input logic [7:0] c, input int n);
    for (int k = 0; k < n; k++) push_rec(c, 1'b1, 1'b0, 1'b0);
  endtask

  // Reference model of one full sequence, starting the cycle after iStart.
  task automatic model_seq(input int cnt, input bit skip, input bit sync);
    e_idx = 4'd0;
    if (!skip) push_phase(8'hFF, RST_N);
    push_phase(8'h00, HOLD_N);
    for (int i = 0; i < cnt; i++) begin
      e_idx    = 4'(i);
      e_serial = tbl[i];
      push_phase(8'h01, HOLD_N);
      push_phase(8'h02, ISSUE_N);
      push_phase(8'h00, HOLD_N);
    end
    if (sync) begin
      push_phase(8'h04, SYNC_N);
      push_phase(8'h00, HOLD_N);
    end
    push_rec(8'h00, 1'b0, 1'b1, 1'b0);
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain_n(input string tag, input int n);
    rec_t exp;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s observed empty scoreboard expected pending record", tag);
        return;
      end
      exp = sb_q.pop_front();
      check(tag, observe(), exp);
    end
  endtask

  task automatic drain(input string tag);
    drain_n(tag, sb_q.size());
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [23:0] d);
    @(negedge sys_clk);
    bus.iCmdWrEn   = 1'b1;
    bus.iCmdWrAddr = a;
    bus.iCmdWrData = d;
    tbl[a]         = d;
    @(posedge sys_clk);
    #1;
    bus.iCmdWrEn = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] cnt, input logic skip, input logic sync);
    @(negedge sys_clk);
    bus.iStart     = 1'b1;
    bus.iCmdCount  = cnt;
    bus.iSkipReset = skip;
    bus.iDoSync    = sync;
    @(posedge sys_clk);
    #1;
    bus.iStart = 1'b0;
  endtask

  initial begin
    rec_t zero_r;
    zero_r = '0;
    iReset         = 1'b1;
    bus.iCmdWrEn   = 1'b0;
    bus.iCmdWrAddr = 4'd0;
    bus.iCmdWrData = 24'd0;
    bus.iCmdCount  = 5'd0;
    bus.iSkipReset = 1'b0;
    bus.iDoSync    = 1'b0;
    bus.iStart     = 1'b0;
    bus.iAbort     = 1'b0;
    e_serial       = 24'd0;
    e_idx          = 4'd0;

    // Reset values
    repeat (2) @(negedge sys_clk);
    check("reset", observe(), zero_r);
    iReset = 1'b0;

    // Test 1: two entries, full reset, no sync
    write_entry(4'd0, 24'h000001);
    write_entry(4'd1, 24'h990008);
    model_seq(2, 1'b0, 1'b0);
    pulse_start(5'd2, 1'b0, 1'b0);
    drain("t1_two_entries");

    // Test 2: no entries, skip reset, sync only
    model_seq(0, 1'b1, 1'b1);
    pulse_start(5'd0, 1'b1, 1'b1);
    drain("t2_sync_only");

    // Test 3: count above 16 is rejected
    push_rec(8'h00, 1'b0, 1'b0, 1'b1);
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
    pulse_start(5'd17, 1'b0, 1'b0);
    drain("t3_reject");

    // Abort while idle has no effect
    @(negedge sys_clk);
    bus.iAbort = 1'b1;
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    bus.iAbort = 1'b0;
    drain("idle_abort");

    // Test 4: abort in the second issue phase, then restart
    model_seq(2, 1'b0, 1'b0);
    pulse_start(5'd2, 1'b0, 1'b0);
    drain_n("t4_pre_abort", RST_N + HOLD_N + HOLD_N + ISSUE_N + HOLD_N + HOLD_N + 3);
    bus.iAbort = 1'b1;
    sb_q.delete();
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
    push_rec(8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    bus.iAbort = 1'b0;
    drain("t4_abort");
    model_seq(2, 1'b0, 1'b0);
    pulse_start(5'd2, 1'b0, 1'b0);
    drain("t4_restart");

    // Test 5: start and table write while busy are both ignored
    model_seq(2, 1'b0, 1'b0);
    pulse_start(5'd2, 1'b0, 1'b0);
    drain_n("t5_pre", 20);
    bus.iStart     = 1'b1;
    bus.iCmdCount  = 5'd1;
    bus.iCmdWrEn   = 1'b1;
    bus.iCmdWrAddr = 4'd1;
    bus.iCmdWrData = 24'hABCDEF;
    @(posedge sys_clk);
    #1;
    bus.iStart   = 1'b0;
    bus.iCmdWrEn = 1'b0;
    drain("t5_ignored");

    // Same idle cycle write + start: entry 0 is written and then played
    @(negedge sys_clk);
    bus.iCmdWrEn   = 1'b1;
    bus.iCmdWrAddr = 4'd0;
    bus.iCmdWrData = 24'h123456;
    tbl[0]         = 24'h123456;
    bus.iStart     = 1'b1;
    bus.iCmdCount  = 5'd1;
    bus.iSkipReset = 1'b1;
    bus.iDoSync    = 1'b0;
    model_seq(1, 1'b1, 1'b0);
    @(posedge sys_clk);
    #1;
    bus.iStart   = 1'b0;
    bus.iCmdWrEn = 1'b0;
    drain("wr_start_same");

    // Test 6: asynchronous reset in the sync phase, then a clean rerun
    model_seq(1, 1'b1, 1'b1);
    pulse_start(5'd1, 1'b1, 1'b1);
    drain_n("t6_pre", HOLD_N + HOLD_N + ISSUE_N + HOLD_N + 2);
    sb_q.delete();
    iReset = 1'b1;
    #1;
    check("t6_async_reset", observe(), zero_r);
    @(negedge sys_clk);
    check("t6_reset_held", observe(), zero_r);
    iReset   = 1'b0;
    e_serial = 24'd0;
    e_idx    = 4'd0;
    write_entry(4'd0, 24'h000001);
    write_entry(4'd1, 24'h990008);
    model_seq(2, 1'b0, 1'b0);
    pulse_start(5'd2, 1'b0, 1'b0);
    drain("t6_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
